// File: rtl/router_fifo.sv
// Synchronous first-word-fall-through FIFO that stores data for one router terminal port.
// It has sticky overflow and underflow flags, and exposes count, full and pndng for the FIFO checker.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int BITS  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [BITS-1:0]            D_in,
  output logic [BITS-1:0]            D_out,
  output logic                       full,
  output logic                       pndng,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BITS-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign pndng = (count_q != '0);
  assign count = count_q;
  assign D_out = pndng ? mem[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // When the FIFO is full, a simultaneous pop frees the head slot, so the push can still be accepted.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && pndng;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // A new error on the same edge as a clear takes priority, so the flag stays set.
    if (push && !push_ok) overflow_d  = 1'b1;
    if (pop && !pop_ok)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset does not clear the storage; only the pointers and the count mark which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= D_in;
  end

  a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
    pop_ok |-> (pndng || count_q != '0));
  a_drop_stable: assert property (@(posedge clk) disable iff (rst)
    (push && full && !pop) |-> (count_d == count_q));

endmodule

// File: tb/tb_router_fifo.sv
// Directed-vector bench for router_fifo (DEPTH=16, BITS=32).
module tb_router_fifo;

  logic        clk;
  logic        rst;
  logic        push, pop, err_clr;
  logic [31:0] D_in;
  logic [31:0] D_out;
  logic        full, pndng, overflow, underflow;
  logic [4:0]  count;

  int n_tests;
  int n_fail;
  logic [31:0] q[$];
  logic [31:0] dummy;

  router_fifo #(.DEPTH(16), .BITS(32)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .D_in(D_in),
    .D_out(D_out), .full(full), .pndng(pndng), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; err_clr = 1'b0; D_in = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    #2;
    check("rst_count", count, 0);
    check("rst_pndng", pndng, 0);
    check("rst_full", full, 0);
    check("rst_dout", D_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    tick();
    rst = 1'b0;
    tick();

    // Fill with 0x0..0xF
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; D_in = i;
      tick();
      check("fill_count", count, i + 1);
      check("fill_dout", D_out, 0);
      check("fill_full", full, (i == 15));
    end
    check("fill_ovf", overflow, 0);

    // Overflow while full
    push = 1'b1; D_in = 32'hDEAD;
    tick();
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    idle();
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      check("drain_dout", D_out, i);
      tick();
    end
    idle();
    check("drain_pndng", pndng, 0);
    check("drain_count", count, 0);
    check("drain_dout0", D_out, 0);
    check("ovf_sticky", overflow, 1);
    err_clr = 1'b1;
    tick();
    idle();
    check("ovf_clr", overflow, 0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; D_in = 32'h100 + i;
      tick();
    end
    push = 1'b1; pop = 1'b1; D_in = 32'hA5;
    check("sim_head", D_out, 32'h100);
    tick();
    idle();
    check("sim_count", count, 16);
    check("sim_full", full, 1);
    check("sim_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      pop = 1'b1;
      check("sim_drain", D_out, 32'h100 + i);
      tick();
    end
    check("sim_last", D_out, 32'hA5);
    check("sim_cnt1", count, 1);
    tick();
    idle();
    check("sim_empty", count, 0);
    check("sim_udf0", underflow, 0);

    // Underflow, clear, empty push+pop
    pop = 1'b1;
    tick();
    idle();
    check("udf_flag", underflow, 1);
    check("udf_count", count, 0);
    err_clr = 1'b1;
    tick();
    idle();
    check("udf_clr", underflow, 0);
    push = 1'b1; pop = 1'b1; D_in = 32'h55;
    tick();
    idle();
    check("pp_count", count, 1);
    check("pp_dout", D_out, 32'h55);
    check("pp_udf", underflow, 1);
    // A new underflow on the same edge as a clear keeps the flag set.
    pop = 1'b1;
    tick();
    pop = 1'b1; err_clr = 1'b1;
    tick();
    idle();
    check("clr_vs_set", underflow, 1);
    err_clr = 1'b1;
    tick();
    idle();

    // Random traffic against the queue model
    q.delete();
    for (int c = 0; c < 40; c++) begin
      logic p, r;
      logic [31:0] d;
      p = ($urandom_range(0, 1) == 1) && (q.size() < 15);
      r = ($urandom_range(0, 1) == 1);
      d = $urandom;
      push = p; pop = r; D_in = d;
      if (q.size() > 0) check("wrap_dout", D_out, q[0]);
      tick();
      if (r && q.size() > 0) dummy = q.pop_front();
      if (p) q.push_back(d);
      check("wrap_count", count, q.size());
    end
    idle();

    // Async reset mid-stream
    while (q.size() > 0) begin
      pop = 1'b1;
      tick();
      dummy = q.pop_front();
    end
    pop = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; D_in = 32'h70 + i;
      tick();
    end
    idle();
    check("pre_rst_count", count, 7);
    check("pre_rst_udf", underflow, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_pndng", pndng, 0);
    check("arst_dout", D_out, 0);
    check("arst_udf", underflow, 0);
    check("arst_ovf", overflow, 0);
    #1;
    rst = 1'b0;
    push = 1'b1; D_in = 32'h1;
    tick();
    idle();
    check("post_dout", D_out, 32'h1);
    check("post_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Parameterised synchronous FIFO: the storage element behind each router terminal port.
- Producer side: push/D_in. Consumer side: pop/D_out with first-word-fall-through (FWFT) output.
- Exports full, pndng and count so the FIFO checker can bind directly to this block.
- Adds sticky overflow/underflow error flags for scoreboard and debug use.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2.
- BITS, 32, data word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write request; D_in is captured on the same edge.
- pop  input  1  read request; removes the head entry.
- D_in  input  BITS  write data.
- D_out  output  BITS  head entry (FWFT); valid when pndng=1.
- full  output  1  1 when count==DEPTH.
- pndng  output  1  1 when count>0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a push that is dropped.
- underflow  output  1  sticky; set by a pop that is ignored.
- err_clr  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous, rst=1): rd_ptr=0, wr_ptr=0, count=0, full=0, pndng=0, D_out=0, overflow=0, underflow=0. Memory contents are not cleared. Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: DEPTH x BITS array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full and pndng: combinational decodes of the registered count; no extra latency.
- D_out:
  - Combinational read of mem[rd_ptr] while pndng=1; 0 while pndng=0.
  - A word pushed into an empty FIFO appears on D_out, with pndng=1, in the cycle after the push edge.
- Effective operations:
  - push_ok = push && (!full || pop)
  - pop_ok = pop && pndng
- Per-edge update:
  - push_ok: mem[wr_ptr] <= D_in; wr_ptr increments.
  - pop_ok: rd_ptr increments.
  - count: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
- Boundary conditions:
  - push while full, no pop: word dropped; count, pointers and memory unchanged; overflow <= 1.
  - push and pop while full: both performed; count stays DEPTH; full stays 1; no overflow.
  - pop while empty, no push: ignored; underflow <= 1.
  - push and pop while empty: push performed, pop ignored; count becomes 1; underflow <= 1. There is no bypass: the word is not consumed in the same cycle.
  - count never exceeds DEPTH and never goes below 0.
- Error flags:
  - Once set, each flag holds until err_clr=1 or rst.
  - If err_clr and a new error occur on the same edge, the set wins and the flag stays 1.
- No state machine beyond the pointer/count registers. Throughput: one push and one pop per cycle.
- Assertions bound to this block:
  - A pop is performed only when pndng || count>0.
  - push && full && !pop leaves count stable.

Test Plan:
- Reset then fill: DEPTH=16, push 16 words 0x0..0xF on consecutive cycles -> count 1..16; full=1 after the 16th edge; D_out=0x0 from cycle 1; overflow=0.
- Overflow: from full, push 0xDEAD with no pop -> count stays 16, overflow=1; drain 16 pops -> read order 0x0..0xF, 0xDEAD never appears, pndng=0 after the last pop.
- Simultaneous at full: full FIFO, push 0xA5 and pop on the same edge -> count stays 16, no overflow; 0xA5 is popped last after 15 further pops.
- Underflow and empty push+pop: empty FIFO, pop alone -> underflow=1, count=0; assert err_clr -> underflow=0; push 0x55 with pop on one edge -> count=1, D_out=0x55, underflow=1.
- Wrap-around: 40 cycles of random push/pop at ~50% each, with the FIFO never reaching full -> pointers wrap; output sequence matches a reference queue model; count always equals the model occupancy.
- Async reset mid-stream: count=7, assert rst between clock edges -> count=0, pndng=0, D_out=0, flags=0 before the next edge; after release, push 0x1 -> D_out=0x1 and count=1 one cycle later.
